// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between instruction fetch and
// load/store, holding address/control stable for LAT cycles and pulsing ready once.
module mem_port_arbiter #(
    parameter int unsigned AW  = 32,
    parameter int unsigned DW  = 32,
    parameter int unsigned LAT = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ready,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ready,
    output logic [DW-1:0] d_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          owner
);

    localparam int unsigned CW = $clog2(LAT + 1);
    localparam logic [CW-1:0] CntLoad = CW'(LAT);
    localparam logic [CW-1:0] CntOne  = CW'(1);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          owner_q, owner_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          grant;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            owner_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        // On a conflict the requester that did not win last time is served.
        grant      = (if_req && d_req) ? ~owner_q : d_req;
        unique case (state_q)
            StIdle: begin
                if (if_req || d_req) begin
                    owner_d = grant;
                    addr_d  = grant ? d_addr : if_addr;
                    we_d    = grant & d_we;
                    if (grant) begin
                        wdata_d = d_wdata;
                    end
                    cnt_d   = CntLoad;
                    state_d = StAccess;
                end
            end
            StAccess: begin
                if (cnt_q == CntOne) begin
                    cnt_d   = '0;
                    state_d = StResp;
                    if (!we_q) begin
                        if (owner_q) begin
                            d_rdata_d = mem_rdata;
                        end else begin
                            if_rdata_d = mem_rdata;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // The counter still holds its load value only in the first ACCESS cycle.
    assign mem_we    = (state_q == StAccess) && we_q && (cnt_q == CntLoad);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign if_ready  = (state_q == StResp) && !owner_q;
    assign d_ready   = (state_q == StResp) && owner_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign busy      = (state_q != StIdle);
    assign owner     = owner_q;

endmodule
